reg_intf_arb: RTL
=================

REG_INTF_ARB -- requirements
Module: reg_intf_arb

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width (32 or 64); strobe width SW = DW/8.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid_i  input  NumReq  per-requester valid.
REQ-007 SHALL have port req_write_i  input  NumReq  per-requester write flag.
REQ-008 SHALL have port req_addr_i  input  NumReq*AW  per-requester address; requester i at bits [i*AW +: AW].
REQ-009 SHALL have port req_wdata_i  input  NumReq*DW  per-requester write data, packed as above.
REQ-010 SHALL have port req_wstrb_i  input  NumReq*SW  per-requester byte strobes, packed as above.
REQ-011 SHALL have port req_ready_o  output  NumReq  per-requester ready.
REQ-012 SHALL have port req_error_o  output  NumReq  per-requester error.
REQ-013 SHALL have port req_rdata_o  output  NumReq*DW  per-requester read data.
REQ-014 SHALL have port slv_valid_o/slv_write_o  output  1  shared-slave valid and write.
REQ-015 SHALL have port slv_addr_o/slv_wdata_o/slv_wstrb_o  output  AW/DW/SW  shared-slave request fields.
REQ-016 SHALL have port slv_ready_i/slv_error_i/slv_rdata_i  input  1/1/DW  shared-slave response.
REQ-017 SHALL have port gnt_idx_o  output  clog2(NumReq)  current owner index; debug only.

Function
REQ-018 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-019 In IDLE: slv_valid_o=0, all slv_* request fields 0, all req_ready_o/req_error_o/req_rdata_o 0.
REQ-020 In IDLE, if any req_valid_i bit is 1, the FSM SHALL register the winner into owner, go to BUSY next edge, and set prio to owner+1 mod NumReq.
REQ-021 Arbitration SHALL be round-robin: winner is the first valid index scanning upward from prio with wrap-around; a single valid requester always wins.
REQ-022 In BUSY: slv_valid_o=1, and slv_write/addr/wdata/wstrb SHALL equal the owner's inputs combinationally.
REQ-023 In BUSY: req_ready_o[owner]=slv_ready_i, req_error_o[owner]=slv_error_i, req_rdata_o[owner]=slv_rdata_i (combinational); non-owners get 0 on all response outputs.
REQ-024 In BUSY with slv_ready_i=1: transaction completes; FSM SHALL return to IDLE next edge.
REQ-025 Minimum latency: requester valid at edge N (IDLE) -> slv_valid_o=1 in cycle N+1; zero-wait slave -> requester ready in cycle N+1; peak throughput 1 transaction per 2 cycles.
REQ-026 Grant SHALL stay locked to owner until completion, regardless of other requesters' valid.
REQ-027 Requesters that are valid but not granted SHALL see ready=0 and MUST hold their request; they are served in a later grant.
REQ-028 Owner dropping valid in BUSY is a protocol violation; the arbiter SHALL keep forwarding the latched owner, and the bench SHALL flag it with an assertion.
REQ-029 slv_valid_o SHALL NOT depend combinationally on slv_ready_i.
REQ-030 gnt_idx_o SHALL equal owner in BUSY and 0 in IDLE.

Reset
REQ-031 rst_ni=0 SHALL immediately force FSM=IDLE, owner=0, prio=0; slv_valid_o=0 and all response outputs 0, including during a BUSY transaction (that transaction is abandoned).
REQ-032 After rst_ni deasserts, the first arbitration SHALL start from prio=0.

Verification
REQ-033 Single requester, NumReq=4: req 2 write addr 0x10 wdata 0xCAFE wstrb 0xF, slave ready immediately -> slv_valid_o high one cycle with those fields, req_ready_o=4'b0100 in that cycle, gnt_idx_o=2.
REQ-034 Round-robin: all 4 valid from reset, zero-wait slave -> grant order 0,1,2,3,0 on successive transactions, one completion every 2 cycles.
REQ-035 Wait states: req 1 read, slave holds ready=0 for 3 cycles then returns rdata 0x1234 error=1 -> slv fields stable 4 cycles; req_rdata of requester 1 = 0x1234, req_error_o=4'b0010 on completion cycle only.
REQ-036 Lock: owner 0 in BUSY, requester 3 raises valid mid-transaction -> slave fields stay requester 0's until completion; requester 3 granted next.
REQ-037 Reset mid-operation: rst_ni low during BUSY -> slv_valid_o=0 in same cycle; after release, requesters 1 and 3 valid -> requester 1 granted first.
REQ-038 Wrap-around: last grant 3, requesters 0 and 2 valid -> requester 0 granted.

Source files
------------

// File: rtl/reg_intf_arb.sv
// rtl/reg_intf_arb.sv - round-robin arbiter sharing one register slave among NumReq requesters
module reg_intf_arb #(
    parameter int NumReq = 4,
    parameter int AW     = 32,
    parameter int DW     = 32,
    localparam int SW    = DW / 8,
    localparam int IW    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumReq-1:0]    req_valid_i,
    input  logic [NumReq-1:0]    req_write_i,
    input  logic [NumReq*AW-1:0] req_addr_i,
    input  logic [NumReq*DW-1:0] req_wdata_i,
    input  logic [NumReq*SW-1:0] req_wstrb_i,
    output logic [NumReq-1:0]    req_ready_o,
    output logic [NumReq-1:0]    req_error_o,
    output logic [NumReq*DW-1:0] req_rdata_o,
    output logic                 slv_valid_o,
    output logic                 slv_write_o,
    output logic [AW-1:0]        slv_addr_o,
    output logic [DW-1:0]        slv_wdata_o,
    output logic [SW-1:0]        slv_wstrb_o,
    input  logic                 slv_ready_i,
    input  logic                 slv_error_i,
    input  logic [DW-1:0]        slv_rdata_i,
    output logic [IW-1:0]        gnt_idx_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] r_prio;
    logic [IW-1:0] w_winner;
    logic          w_found;
    logic          w_grant;

    // Scan upward from r_prio with wrap-around; first valid requester wins.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NumReq; k++) begin
            idx = (int'(r_prio) + k) % NumReq;
            if (!w_found && req_valid_i[idx]) begin
                w_found  = 1'b1;
                w_winner = IW'(idx);
            end
        end
    end

    assign w_grant = (r_state == IDLE) && w_found;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_prio  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner <= w_winner;
                r_prio  <= IW'((int'(w_winner) + 1) % NumReq);
            end
        end
    end

    // Outputs derive only from the registered owner, so slv_valid_o never sees slv_ready_i.
    always_comb begin
        w_state_nxt = r_state;
        slv_valid_o = 1'b0;
        slv_write_o = 1'b0;
        slv_addr_o  = '0;
        slv_wdata_o = '0;
        slv_wstrb_o = '0;
        req_ready_o = '0;
        req_error_o = '0;
        req_rdata_o = '0;
        gnt_idx_o   = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                slv_valid_o                   = 1'b1;
                slv_write_o                   = req_write_i[r_owner];
                slv_addr_o                    = req_addr_i[r_owner*AW +: AW];
                slv_wdata_o                   = req_wdata_i[r_owner*DW +: DW];
                slv_wstrb_o                   = req_wstrb_i[r_owner*SW +: SW];
                req_ready_o[r_owner]          = slv_ready_i;
                req_error_o[r_owner]          = slv_error_i;
                req_rdata_o[r_owner*DW +: DW] = slv_rdata_i;
                gnt_idx_o                     = r_owner;
                if (slv_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
